// File: rtl/wb_writeback_regfile.sv
// Write-back stage: picks load data or the ALU result and commits it to a
// 32-entry integer register file. Two combinational read ports see the value
// being committed this cycle (write-through). Also provides a registered
// forwarding record and a retired-instruction counter.
module wb_writeback_regfile #(
  parameter int DATA_LEN         = 64,
  parameter int CONTROL_LINE     = 2,
  parameter int INSTRUCTION_PART = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [CONTROL_LINE-1:0]     control_in,
  input  logic [DATA_LEN-1:0]         rd_data,
  input  logic [DATA_LEN-1:0]         addr,
  input  logic [INSTRUCTION_PART-1:0] instruction_part,
  input  logic [4:0]                  rs1_idx,
  input  logic [4:0]                  rs2_idx,
  output logic [DATA_LEN-1:0]         rs1_data,
  output logic [DATA_LEN-1:0]         rs2_data,
  output logic                        fwd_valid,
  output logic [4:0]                  fwd_rd,
  output logic [DATA_LEN-1:0]         fwd_data,
  output logic [31:0]                 retire_count
);

  logic                reg_write;
  logic                mem_to_reg;
  logic                commit;
  logic [DATA_LEN-1:0] wb_value;

  // Entry 0 is never written, so it stays zero from reset onward; the read
  // ports still force zero for index 0 so x0 never depends on storage.
  logic [DATA_LEN-1:0] regs [0:31];

  assign reg_write  = control_in[0];
  assign mem_to_reg = control_in[1];

  // Select the write-back value and decide whether this cycle commits;
  // while reset is held nothing counts as a commit, so the bypass cannot
  // leak a value onto the read ports either.
  always_comb begin
    wb_value = addr;
    if (mem_to_reg) begin
      wb_value = rd_data;
    end
    commit = valid_in && reg_write && (instruction_part != '0) && !rst;
  end

  // Read ports: x0 is hard zero, then the bypass for an in-flight commit,
  // otherwise the stored register.
  always_comb begin
    rs1_data = regs[rs1_idx];
    rs2_data = regs[rs2_idx];
    if (commit && (rs1_idx == 5'(instruction_part))) begin
      rs1_data = wb_value;
    end
    if (commit && (rs2_idx == 5'(instruction_part))) begin
      rs2_data = wb_value;
    end
    if (rs1_idx == 5'd0) begin
      rs1_data = '0;
    end
    if (rs2_idx == 5'd0) begin
      rs2_data = '0;
    end
  end

  // Register file storage; only the committed destination changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[5'(instruction_part)] <= wb_value;
    end
  end

  // Forwarding record: valid pulses per commit, index/data hold between commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= commit;
      if (commit) begin
        fwd_rd   <= 5'(instruction_part);
        fwd_data <= wb_value;
      end
    end
  end

  // Retired-instruction counter: every real entry counts, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
    end else if (valid_in) begin
      retire_count <= retire_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_writeback_regfile.sv
// Scoreboard bench for wb_writeback_regfile: each directed step pushes its
// hand-computed expected outputs; a monitor pops and compares on negedge.
module tb_wb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [1:0]  control_in;
  logic [63:0] rd_data;
  logic [63:0] addr;
  logic [4:0]  instruction_part;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic [31:0] retire_count;

  typedef struct {
    string       tag;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        fv;
    logic [4:0]  frd;
    logic [63:0] fdata;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vec_count = 0;
  int   miss_count = 0;

  wb_writeback_regfile #(
    .DATA_LEN(64),
    .CONTROL_LINE(2),
    .INSTRUCTION_PART(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .control_in(control_in),
    .rd_data(rd_data),
    .addr(addr),
    .instruction_part(instruction_part),
    .rs1_idx(rs1_idx),
    .rs2_idx(rs2_idx),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd),
    .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input string field,
                              input logic [63:0] act, input logic [63:0] want);
    vec_count++;
    if (act !== want) begin
      miss_count++;
      $display("[TB] FAIL %s.%s actual=0x%0h expected=0x%0h", tag, field, act, want);
    end
  endtask

  // Monitor: compares every DUT output against the queued expectation
  // on the falling edge, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e.tag, "rs1_data",     rs1_data,             e.rs1);
        check_output(e.tag, "rs2_data",     rs2_data,             e.rs2);
        check_output(e.tag, "fwd_valid",    64'(fwd_valid),       64'(e.fv));
        check_output(e.tag, "fwd_rd",       64'(fwd_rd),          64'(e.frd));
        check_output(e.tag, "fwd_data",     fwd_data,             e.fdata);
        check_output(e.tag, "retire_count", 64'(retire_count),    64'(e.cnt));
      end
    end
  end

  // One cycle of stimulus, entered just after a rising edge. With
  // mid_reset set, rst is raised partway through the cycle and dropped
  // again just after the following rising edge.
  task automatic apply_stimulus(input string tag, input logic v, input logic [1:0] c,
                                input logic [63:0] rdd, input logic [63:0] ad,
                                input logic [4:0] rdi, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [63:0] e1,
                                input logic [63:0] e2, input logic efv,
                                input logic [4:0] efrd, input logic [63:0] efd,
                                input logic [31:0] ecnt, input bit mid_reset);
    exp_t e;
    valid_in         = v;
    control_in       = c;
    rd_data          = rdd;
    addr             = ad;
    instruction_part = rdi;
    rs1_idx          = r1;
    rs2_idx          = r2;
    if (mid_reset) begin
      #1 rst = 1'b1;
    end
    e.tag = tag; e.rs1 = e1; e.rs2 = e2; e.fv = efv;
    e.frd = efrd; e.fdata = efd; e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (mid_reset) begin
      rst = 1'b0;
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    rst = 1'b1;
    valid_in = 0; control_in = 0; rd_data = 0; addr = 0;
    instruction_part = 0; rs1_idx = 0; rs2_idx = 0;
    @(posedge clk);
    #1;
    //             tag         v  ctl    rd_data  addr          rd  rs1 rs2 exp_rs1        exp_rs2        fv frd fdata          cnt           rst
    apply_stimulus("reset0",   0, 2'b00, 64'h0,   64'h0,        0,  5,  7,  64'h0,         64'h0,         0, 0,  64'h0,         32'h0,        0);
    rst = 1'b0;
    apply_stimulus("load_x5",  1, 2'b01, 64'h0,   64'h1234,     5,  5,  0,  64'h1234,      64'h0,         0, 0,  64'h0,         32'h0,        0);
    apply_stimulus("hold_x5",  0, 2'b00, 64'h0,   64'h0,        0,  5,  5,  64'h1234,      64'h1234,      1, 5,  64'h1234,      32'h1,        0);
    apply_stimulus("hold_x5b", 0, 2'b01, 64'h0,   64'h0,        0,  5,  0,  64'h1234,      64'h0,         0, 5,  64'h1234,      32'h1,        0);
    apply_stimulus("midrst",   0, 2'b00, 64'h0,   64'h0,        0,  5,  5,  64'h0,         64'h0,         0, 0,  64'h0,         32'h0,        1);
    apply_stimulus("alu_wb",   1, 2'b01, 64'h0,   64'hDEADBEEF, 7,  7,  5,  64'hDEADBEEF,  64'h0,         0, 0,  64'h0,         32'h0,        0);
    apply_stimulus("alu_idle", 0, 2'b00, 64'h0,   64'h0,        0,  7,  0,  64'hDEADBEEF,  64'h0,         1, 7,  64'hDEADBEEF,  32'h1,        0);
    apply_stimulus("load_wb",  1, 2'b11, 64'hA5A5,64'h1,        3,  3,  7,  64'hA5A5,      64'hDEADBEEF,  0, 7,  64'hDEADBEEF,  32'h1,        0);
    apply_stimulus("x0_write", 1, 2'b01, 64'h0,   64'hFF,       0,  0,  3,  64'h0,         64'hA5A5,      1, 3,  64'hA5A5,      32'h2,        0);
    apply_stimulus("no_write", 1, 2'b10, 64'h55,  64'h55,       4,  4,  0,  64'h0,         64'h0,         0, 3,  64'hA5A5,      32'h3,        0);
    apply_stimulus("bubble",   0, 2'b01, 64'h0,   64'h77,       9,  9,  4,  64'h0,         64'h0,         0, 3,  64'hA5A5,      32'h4,        0);
    apply_stimulus("post_bub", 0, 2'b00, 64'h0,   64'h0,        0,  9,  3,  64'h0,         64'hA5A5,      0, 3,  64'hA5A5,      32'h4,        0);
    apply_stimulus("b2b_1",    1, 2'b01, 64'h0,   64'h1,        10, 10, 10, 64'h1,         64'h1,         0, 3,  64'hA5A5,      32'h4,        0);
    apply_stimulus("b2b_2",    1, 2'b01, 64'h0,   64'h2,        10, 10, 10, 64'h2,         64'h2,         1, 10, 64'h1,         32'h5,        0);
    apply_stimulus("b2b_idle", 0, 2'b00, 64'h0,   64'h0,        0,  10, 10, 64'h2,         64'h2,         1, 10, 64'h2,         32'h6,        0);
    // Jump the counter close to its wrap point instead of retiring 2^32 entries.
    force dut.retire_count = 32'hFFFF_FFFE;
    #1 release dut.retire_count;
    apply_stimulus("cnt_fe",   1, 2'b00, 64'h0,   64'h0,        0,  10, 0,  64'h2,         64'h0,         0, 10, 64'h2,         32'hFFFF_FFFE,0);
    apply_stimulus("cnt_ff",   1, 2'b00, 64'h0,   64'h0,        0,  0,  10, 64'h0,         64'h2,         0, 10, 64'h2,         32'hFFFF_FFFF,0);
    apply_stimulus("cnt_wrap", 0, 2'b00, 64'h0,   64'h0,        0,  3,  7,  64'hA5A5,      64'hDEADBEEF,  0, 10, 64'h2,         32'h0,        0);
    valid_in = 0; control_in = 0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      miss_count++;
      $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/wb_writeback_regfile.md
# wb_writeback_regfile

Write-back stage of the multi-cycle RISC-V core, consuming the outputs of the MEM/WB pipeline register. Each cycle it selects the write-back value, either load data or the ALU result, and commits it to a 32-entry integer register file. It serves two combinational read ports with write-through bypass. It also publishes a registered forwarding record and a retired-instruction counter.

## Interface
Parameters:
- DATA_LEN, 64, register and data width
- CONTROL_LINE, 2, width of the write-back control field
- INSTRUCTION_PART, 5, width of the destination register index

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- valid_in  in  1  MEM/WB entry holds a real instruction (0 = bubble)
- control_in  in  CONTROL_LINE  bit0 reg_write, bit1 mem_to_reg; any other bits are ignored
- rd_data  in  DATA_LEN  load data from the memory stage
- addr  in  DATA_LEN  ALU result / effective address
- instruction_part  in  INSTRUCTION_PART  destination register index rd
- rs1_idx  in  5  read port 1 index
- rs2_idx  in  5  read port 2 index
- rs1_data  out  DATA_LEN  read port 1 data (combinational)
- rs2_data  out  DATA_LEN  read port 2 data (combinational)
- fwd_valid  out  1  last cycle committed a register write
- fwd_rd  out  5  register index of that write
- fwd_data  out  DATA_LEN  value of that write
- retire_count  out  32  number of valid entries retired

## Operation
- wb_value = mem_to_reg ? rd_data : addr.
- A commit occurs when valid_in = 1, reg_write = 1 and instruction_part != 0.
- On commit, regs[instruction_part] <= wb_value. All other entries hold.
- x0 reads 0 always. A write to x0 is discarded and is not a commit.
- valid_in = 0 suppresses all effects except the forwarding update described below. The control, data and index inputs are don't-care in that case.
- Read ports:
  - rsN_idx == 0 returns 0.
  - If a commit is occurring this cycle and rsN_idx == instruction_part, the port returns wb_value (write-through bypass).
  - Otherwise the port returns regs[rsN_idx].
- Forwarding record, updated every rising edge:
  - fwd_valid <= commit.
  - fwd_rd and fwd_data load instruction_part and wb_value only on a commit. Otherwise they hold their previous values.
- retire_count increments by 1 on every edge where valid_in = 1, regardless of reg_write or rd. It wraps from 0xFFFF_FFFF to 0.
- Both read ports may address the same register, including the one being written. Both then return identical data.

## Timing
- Reset (asynchronous assert, released synchronously by the environment):
  - regs[1..31] = 0.
  - fwd_valid = 0, fwd_rd = 0, fwd_data = 0, retire_count = 0.
  - rs1_data and rs2_data reflect the zeroed file immediately.
- Reset asserted mid-operation:
  - Any write due on that edge is lost.
  - All state clears at once, without waiting for clk.
- Commit latency:
  - Value is visible on the read ports in the same cycle through the bypass.
  - Value is held in the file from the next edge.
  - Value appears on fwd_* one edge after the commit cycle.
- No handshake or stall. One entry is consumed per cycle and the block is always ready.
- Back-to-back commits to the same rd: the later value wins. The bypass shows the current cycle's value.

## Test plan
- Reset: load x5 = 0x1234 and then assert rst mid-cycle. Expect x5 to read 0, fwd_valid = 0 and retire_count = 0 before the next clk edge.
- ALU write-back: valid = 1, control = 2'b01, addr = 0xDEAD_BEEF, rd = 7, rs1_idx = 7. Expect rs1_data = 0xDEAD_BEEF in the same cycle. After the edge expect fwd_valid = 1, fwd_rd = 7, fwd_data = 0xDEAD_BEEF, and rs1_data still 0xDEAD_BEEF once the inputs go idle.
- Load write-back: control = 2'b11, rd_data = 0xA5A5, addr = 0x1, rd = 3. Expect x3 = 0xA5A5, not 0x1.
- x0 protection and non-writes:
  - rd = 0, reg_write = 1, addr = 0xFF: expect x0 still reads 0 and fwd_valid = 0.
  - reg_write = 0, rd = 4: expect x4 unchanged.
  - In both cases expect retire_count to increment by 1.
- Bubble plus counter wrap:
  - valid_in = 0 with reg_write = 1, rd = 9: expect no write and no count.
  - Preload retire_count to 0xFFFF_FFFF (one valid step from 0xFFFF_FFFE), then apply one more valid entry. Expect retire_count = 0.
- Back-to-back same rd: write x10 = 1 and then x10 = 2 on consecutive edges with rs1_idx = rs2_idx = 10. Expect both ports to show 1, then 2. fwd_data follows one cycle behind.
